// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and a
// helper that derives the byte-strobe width from the data width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-phase wait counter; flags the last allowed wait cycle.
// A TIMEOUT of 0 keeps the flag permanently low so a transfer can wait forever.
module apb_timeout_ctr #(
    parameter int W       = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int            LIMIT_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [W-1:0]  LIMIT   = W'(LIMIT_I);
    localparam logic [W-1:0]  CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment without wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {W{1'b0}};
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB3/APB4 requester: one command in, SETUP/ACCESS on the
// bus, one response out. All outputs are flops except cmd_ready.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = strb_width(DATA_W)
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_e        state_q,       state_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic              pwrite_q,      pwrite_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic [STRB_W-1:0] pstrb_q,       pstrb_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic cnt_clr_s;
    logic cnt_inc_s;
    logic expired_s;

    // The wait counter restarts as the bus moves into ACCESS.
    assign cnt_clr_s = (state_q == SETUP);
    assign cnt_inc_s = (state_q == ACCESS) && !pready;

    apb_timeout_ctr #(
        .W       (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (pclk),
        .rst_i     (prst),
        .clr_i     (cnt_clr_s),
        .inc_i     (cnt_inc_s),
        .expired_o (expired_s)
    );

    // FSM next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : {STRB_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A ready slave wins over an expiring counter in the same cycle.
                if (pready) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (expired_s) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = {DATA_W{1'b0}};
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d   = ACCESS;
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything including responses.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q       <= IDLE;
            paddr_q       <= {ADDR_W{1'b0}};
            pwrite_q      <= 1'b0;
            pwdata_q      <= {DATA_W{1'b0}};
            pstrb_q       <= {STRB_W{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign paddr       = paddr_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl (TIMEOUT=4): latency, wait states, slave
// error, timeout abort, response back-pressure and mid-transfer reset.
module tb_apb_master_ctrl;

    logic        pclk;
    logic        prst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks;
    int n_errors;

    apb_master_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .pclk        (pclk),
        .prst        (prst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns so outputs are sampled off-edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check_eq("cmd_ready_back",    32'(cmd_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state
        step();
        step();
        prst = 1'b0;
        check_eq("rst_psel",      32'(psel),      32'd0);
        check_eq("rst_penable",   32'(penable),   32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_paddr",     paddr,          32'h0);
        check_eq("rst_pstrb",     32'(pstrb),     32'h0);

        // 1: zero-wait write; psel one edge after accept, penable two, rsp three
        drive_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        pready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_eq("t1_setup_psel",    32'(psel),      32'd1);
        check_eq("t1_setup_penable", 32'(penable),   32'd0);
        check_eq("t1_cmd_ready",     32'(cmd_ready), 32'd0);
        check_eq("t1_paddr",         paddr,          32'h0000_0010);
        check_eq("t1_pwdata",        pwdata,         32'hDEAD_BEEF);
        check_eq("t1_pstrb",         32'(pstrb),     32'hF);
        check_eq("t1_pwrite",        32'(pwrite),    32'd1);
        step();
        check_eq("t1_access_psel",    32'(psel),    32'd1);
        check_eq("t1_access_penable", 32'(penable), 32'd1);
        step();
        check_eq("t1_rsp_valid",   32'(rsp_valid),   32'd1);
        check_eq("t1_rsp_psel",    32'(psel),        32'd0);
        check_eq("t1_rsp_penable", 32'(penable),     32'd0);
        check_eq("t1_rsp_err",     32'(rsp_err),     32'd0);
        check_eq("t1_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("t1_rsp_rdata",   rsp_rdata,        32'h0);
        consume_rsp();

        // 2: read with three wait states; penable high for four cycles
        drive_cmd(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
        pready = 1'b0;
        prdata = 32'h1234_5678;
        step();
        cmd_valid = 1'b0;
        check_eq("t2_pstrb_read", 32'(pstrb),  32'h0);
        check_eq("t2_pwrite",     32'(pwrite), 32'd0);
        check_eq("t2_paddr",      paddr,       32'h0000_0020);
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_wait_penable", 32'(penable),   32'd1);
            check_eq("t2_wait_no_rsp",  32'(rsp_valid), 32'd0);
            step();
        end
        pready = 1'b1;
        check_eq("t2_last_penable", 32'(penable), 32'd1);
        step();
        pready = 1'b0;
        check_eq("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t2_rsp_rdata", rsp_rdata,      32'h1234_5678);
        check_eq("t2_rsp_err",   32'(rsp_err),   32'd0);
        check_eq("t2_penable",   32'(penable),   32'd0);
        consume_rsp();

        // 3: write completing with slave error
        drive_cmd(1'b1, 32'h0000_0030, 32'h0000_0001, 4'h3);
        pready  = 1'b1;
        pslverr = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_eq("t3_pstrb", 32'(pstrb), 32'h3);
        step();
        step();
        pslverr = 1'b0;
        check_eq("t3_rsp_valid",   32'(rsp_valid),   32'd1);
        check_eq("t3_rsp_err",     32'(rsp_err),     32'd1);
        check_eq("t3_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("t3_rsp_rdata",   rsp_rdata,        32'h0);
        consume_rsp();

        // 4: hung slave, aborted after exactly four ACCESS cycles
        drive_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_access_psel",    32'(psel),      32'd1);
            check_eq("t4_access_penable", 32'(penable),   32'd1);
            check_eq("t4_no_early_rsp",   32'(rsp_valid), 32'd0);
            step();
        end
        check_eq("t4_psel_dropped", 32'(psel),        32'd0);
        check_eq("t4_rsp_valid",    32'(rsp_valid),   32'd1);
        check_eq("t4_rsp_err",      32'(rsp_err),     32'd1);
        check_eq("t4_rsp_timeout",  32'(rsp_timeout), 32'd1);
        check_eq("t4_rsp_rdata",    rsp_rdata,        32'h0);
        consume_rsp();

        // 5: response back-pressure with a second command already waiting
        drive_cmd(1'b1, 32'h0000_0050, 32'hA5A5_0001, 4'hC);
        pready = 1'b1;
        step();
        drive_cmd(1'b0, 32'h0000_0060, 32'h0, 4'hF);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_cmd_ready_low", 32'(cmd_ready),   32'd0);
            check_eq("t5_rsp_valid",     32'(rsp_valid),   32'd1);
            check_eq("t5_rsp_err",       32'(rsp_err),     32'd0);
            check_eq("t5_rsp_rdata",     rsp_rdata,        32'h0);
            check_eq("t5_paddr_held",    paddr,            32'h0000_0050);
            check_eq("t5_psel_low",      32'(psel),        32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("t5_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("t5_idle_psel",      32'(psel),      32'd0);
        check_eq("t5_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        prdata = 32'h0BAD_F00D;
        step();
        cmd_valid = 1'b0;
        check_eq("t5_second_psel",  32'(psel),   32'd1);
        check_eq("t5_second_paddr", paddr,       32'h0000_0060);
        check_eq("t5_second_pwr",   32'(pwrite), 32'd0);
        check_eq("t5_second_pstrb", 32'(pstrb),  32'h0);
        step();
        step();
        check_eq("t5_second_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t5_second_rdata",     rsp_rdata,      32'h0BAD_F00D);
        consume_rsp();

        // 6: reset during ACCESS discards the transfer
        drive_cmd(1'b0, 32'h0000_0070, 32'h0, 4'h0);
        pready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check_eq("t6_in_access", 32'(penable), 32'd1);
        prst = 1'b1;
        step();
        prst   = 1'b0;
        pready = 1'b1;
        check_eq("t6_rst_psel",      32'(psel),      32'd0);
        check_eq("t6_rst_penable",   32'(penable),   32'd0);
        check_eq("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        check_eq("t6_no_late_rsp", 32'(rsp_valid), 32'd0);
        drive_cmd(1'b1, 32'h0000_0080, 32'h5555_AAAA, 4'h1);
        step();
        cmd_valid = 1'b0;
        check_eq("t6_new_psel",  32'(psel),  32'd1);
        check_eq("t6_new_paddr", paddr,      32'h0000_0080);
        check_eq("t6_new_pstrb", 32'(pstrb), 32'h1);
        step();
        step();
        check_eq("t6_new_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t6_new_rsp_err",   32'(rsp_err),   32'd0);
        consume_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
